ccff_chain_loader: RTL and testbench



---
 rtl/ccff_chain_loader_pkg.sv | 20 ++
 rtl/ccff_chain_loader_if.sv | 13 +
 rtl/ccff_chain_loader_crc8.sv | 30 +++
 rtl/ccff_chain_loader.sv | 153 +++++++++++++++
 tb/tb_ccff_chain_loader.sv | 342 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ccff_chain_loader_pkg.sv
// Shared types and constants for the ccff chain loader: FSM states, CRC-8
// parameters and the words-per-load helper.
package ccff_loader_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    VERIFY = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [7:0] CRC8_POLY = 8'h07;
  localparam logic [7:0] CRC8_INIT = 8'h00;

  // Number of configuration words needed to cover the whole chain.
  function automatic int words_per_load(input int chain_len, input int word_w);
    return (chain_len + word_w - 1) / word_w;
  endfunction

endpackage

// File: rtl/ccff_chain_loader_if.sv
// Configuration-word handshake into the chain loader.
// Valid/ready: a word transfers on a prog_clk edge where cfg_valid and cfg_ready
// are both 1; while cfg_valid=1 and cfg_ready=0 the source holds cfg_data stable.
interface ccff_chain_loader_if #(
  parameter int WORD_W = 8
);
  logic [WORD_W-1:0] cfg_data;
  logic              cfg_valid;
  logic              cfg_ready;

  modport master (output cfg_data, output cfg_valid, input cfg_ready);
  modport slave  (input cfg_data, input cfg_valid, output cfg_ready);
endinterface

// File: rtl/ccff_chain_loader_crc8.sv
// Serial CRC-8 (one input bit per enabled cycle) with synchronous clear.
// crc_next is the value the register takes if the current bit is absorbed.
module ccff_crc8_serial
  import ccff_loader_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       en,
  input  logic       din,
  output logic [7:0] crc,
  output logic [7:0] crc_next
);

  logic fb;

  always_comb begin
    fb       = crc[7] ^ din;
    crc_next = {crc[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      crc <= CRC8_INIT;
    end else if (en) begin
      crc <= crc_next;
    end
  end

endmodule

// File: rtl/ccff_chain_loader.sv
// Serialises configuration words MSB-first onto a ccff chain with a shift enable.
// Optional read-back verify through ccff_tail is built when CCFF_LOADER_VERIFY_EN is defined.
module ccff_chain_loader
  import ccff_loader_pkg::*;
#(
  parameter int WORD_W    = 8,
  parameter int CHAIN_LEN = 18
) (
  input  logic                       prog_clk,
  input  logic                       reset,
  ccff_chain_loader_if.slave         cfg,
  output logic                       ccff_head,
  input  logic                       ccff_tail,
  output logic                       prog_clk_en,
  output logic                       load_busy,
  output logic                       load_done,
  output logic                       load_err,
  output state_t                     state
);

  localparam int REM_W = $clog2(CHAIN_LEN + 1);
  localparam int IDX_W = $clog2(WORD_W + 1);
  localparam logic [REM_W-1:0] REM_FULL = REM_W'(CHAIN_LEN);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORD_W - 1);

  logic [WORD_W-1:0] word_sr;   // unpresented bits of the current word, MSB-aligned
  logic [IDX_W-1:0]  bit_idx;   // unpresented bits left in word_sr
  logic [REM_W-1:0]  rem;       // chain bits not yet shifted, including the one on head
  logic [REM_W-1:0]  rem_left;
  logic              head_q;
  logic              ready;
  logic              accept;
  logic              start_load;

  // A bit leaves rem on the edge that ends a cycle with prog_clk_en=1.
  assign rem_left = rem - {{(REM_W-1){1'b0}}, prog_clk_en};

  always_comb begin
    ready = 1'b0;
    if (!reset) begin
      case (state)
        IDLE, DONE: ready = 1'b1;
        SHIFT:      ready = (bit_idx == '0) && (rem > {{(REM_W-1){1'b0}}, prog_clk_en});
        default:    ready = 1'b0;
      endcase
    end
  end

  assign cfg.cfg_ready = ready;
  assign accept        = cfg.cfg_valid && ready;
  assign start_load    = accept && ((state == IDLE) || (state == DONE));
  assign load_busy     = (state == SHIFT) || (state == VERIFY);

`ifdef CCFF_LOADER_VERIFY_EN
  logic [REM_W-1:0] v_cnt;
  logic [7:0]       crc_load;
  logic [7:0]       crc_tail_next;
  logic [7:0]       crc_load_next_unused;
  logic [7:0]       crc_tail_unused;

  ccff_crc8_serial u_crc_load (
    .clk      (prog_clk),
    .reset    (reset),
    .clear    (start_load),
    .en       ((state == SHIFT) && prog_clk_en),
    .din      (head_q),
    .crc      (crc_load),
    .crc_next (crc_load_next_unused)
  );

  ccff_crc8_serial u_crc_tail (
    .clk      (prog_clk),
    .reset    (reset),
    .clear    (start_load),
    .en       (state == VERIFY),
    .din      (ccff_tail),
    .crc      (crc_tail_unused),
    .crc_next (crc_tail_next)
  );

  // Recirculate tail to head so a verify pass leaves the chain image intact.
  assign ccff_head = (state == VERIFY) ? ccff_tail : head_q;
`else
  wire unused_tail = &{1'b0, ccff_tail};
  assign ccff_head = head_q;
`endif

  always_ff @(posedge prog_clk) begin
    if (reset) begin
      state       <= IDLE;
      head_q      <= 1'b0;
      prog_clk_en <= 1'b0;
      load_done   <= 1'b0;
      load_err    <= 1'b0;
      rem         <= '0;
      bit_idx     <= '0;
      word_sr     <= '0;
`ifdef CCFF_LOADER_VERIFY_EN
      v_cnt       <= '0;
`endif
    end else begin
      if (start_load) begin
        state     <= SHIFT;
        load_done <= 1'b0;
        load_err  <= 1'b0;
        rem       <= REM_FULL;
      end
      if (accept) begin
        head_q      <= cfg.cfg_data[WORD_W-1];
        word_sr     <= {cfg.cfg_data[WORD_W-2:0], 1'b0};
        bit_idx     <= IDX_LAST;
        prog_clk_en <= 1'b1;
      end
      case (state)
        SHIFT: begin
          rem <= rem_left;
          if (rem_left == '0) begin
`ifdef CCFF_LOADER_VERIFY_EN
            state       <= VERIFY;
            prog_clk_en <= 1'b1;
            v_cnt       <= REM_FULL;
`else
            state       <= DONE;
            prog_clk_en <= 1'b0;
            load_done   <= 1'b1;
`endif
          end else if (bit_idx != '0) begin
            head_q      <= word_sr[WORD_W-1];
            word_sr     <= {word_sr[WORD_W-2:0], 1'b0};
            bit_idx     <= bit_idx - 1'b1;
            prog_clk_en <= 1'b1;
          end else if (!accept) begin
            // Starved: hold ccff_head and stop the chain until a word arrives.
            prog_clk_en <= 1'b0;
          end
        end
`ifdef CCFF_LOADER_VERIFY_EN
        VERIFY: begin
          v_cnt <= v_cnt - 1'b1;
          if (v_cnt == {{(REM_W-1){1'b0}}, 1'b1}) begin
            state       <= DONE;
            prog_clk_en <= 1'b0;
            load_done   <= 1'b1;
            load_err    <= (crc_load != crc_tail_next);
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Bench for ccff_chain_loader: models the downstream chain as a shift register
// and predicts every enabled cycle from the word acceptance times.
module tb_ccff_chain_loader;
  import ccff_loader_pkg::*;

  localparam int W  = 8;
  localparam int L  = 18;
  localparam int NW = words_per_load(L, W);
  localparam logic [L-1:0] FLIP_MASK = 18'h00020;
  localparam logic [W-1:0] JUNK      = 8'h5A;
`ifdef CCFF_LOADER_VERIFY_EN
  localparam int LOAD_CYC = 2 * L + 1;
`else
  localparam int LOAD_CYC = L + 1;
`endif

  // clock / reset
  logic prog_clk = 1'b0;
  logic reset    = 1'b1;
  always #5 prog_clk = ~prog_clk;

  ccff_chain_loader_if #(.WORD_W(W)) cfg ();
  logic   ccff_head, ccff_tail, prog_clk_en, load_busy, load_done, load_err;
  state_t state;

  ccff_chain_loader #(.WORD_W(W), .CHAIN_LEN(L)) dut (
    .prog_clk    (prog_clk),
    .reset       (reset),
    .cfg         (cfg),
    .ccff_head   (ccff_head),
    .ccff_tail   (ccff_tail),
    .prog_clk_en (prog_clk_en),
    .load_busy   (load_busy),
    .load_done   (load_done),
    .load_err    (load_err),
    .state       (state)
  );

  // downstream chain model
  logic [L-1:0] chain    = '0;
  logic         flip_req = 1'b0;
  assign ccff_tail = chain[L-1];
  always @(posedge prog_clk)
    chain <= (prog_clk_en ? {chain[L-2:0], ccff_head} : chain) ^ (flip_req ? FLIP_MASK : '0);

  // scoreboard state
  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] words[$];
  int           gaps[NW];
  logic [0:0]   exp_q[$];
  logic [L-1:0] img;
  int           t0_cyc, done_cyc, en_seen;

  // Drives one load. Word j (j>=1) is offered gaps[j] cycles after word j-1 is taken.
  // Expected: bit k is shifted in the first cycle after its word was accepted and
  // after bit k-1; a new word is wanted once the previous word's last bit is on head.
  task automatic run_load(input int stop_bits, input bit flip);
    int j, k, phase, a_prev, vleft;
    logic last_bit, acc, en_exp, rdy_exp;
    bit finished;
    exp_q.delete();
    img = '0;
    for (int b = 0; b < L; b++) begin
      logic [W-1:0] wv;
      wv = words[b / W];
      exp_q.push_back(wv[W-1-(b % W)]);
      img[L-1-b] = wv[W-1-(b % W)];
    end
    j = 0; k = 0; phase = 0; a_prev = 0; vleft = 0;
    en_seen = 0; t0_cyc = -1; done_cyc = -1; finished = 0; last_bit = 1'b0;
    @(posedge prog_clk); #1;
    cfg.cfg_valid = 1'b1;
    cfg.cfg_data  = words[0];
    for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
      @(negedge prog_clk);
      acc = cfg.cfg_valid && cfg.cfg_ready;
      case (phase)
        0: begin
          checks++;
          if (cfg.cfg_ready !== 1'b1) begin
            errors++; $display("FAIL ready_start: got %b expected 1", cfg.cfg_ready);
          end
          t0_cyc = cyc;
          phase  = 1;
        end
        1: begin
          en_exp  = (j > k / W);
          rdy_exp = (j < NW) && (k >= j * W - 1);
          checks++;
          if (prog_clk_en !== en_exp) begin
            errors++; $display("FAIL shift_en bit %0d: got %b expected %b", k, prog_clk_en, en_exp);
          end
          checks++;
          if (cfg.cfg_ready !== rdy_exp) begin
            errors++; $display("FAIL shift_ready bit %0d: got %b expected %b", k, cfg.cfg_ready, rdy_exp);
          end
          checks++;
          if ({load_busy, load_done, load_err} !== 3'b100 || state !== SHIFT) begin
            errors++; $display("FAIL shift_flags: got busy/done/err %b%b%b state %0d expected 100 state %0d",
                               load_busy, load_done, load_err, state, SHIFT);
          end
          if (en_exp) begin
            last_bit = exp_q.pop_front();
            checks++;
            if (ccff_head !== last_bit) begin
              errors++; $display("FAIL head bit %0d: got %b expected %b", k, ccff_head, last_bit);
            end
            k++;
            en_seen++;
          end else begin
            checks++;
            if (ccff_head !== last_bit) begin
              errors++; $display("FAIL head_hold: got %b expected %b", ccff_head, last_bit);
            end
          end
          if (k == L) begin
`ifdef CCFF_LOADER_VERIFY_EN
            phase = 2;
            vleft = L;
`else
            phase = 3;
`endif
          end
          if (stop_bits > 0 && k == stop_bits) finished = 1;
        end
`ifdef CCFF_LOADER_VERIFY_EN
        2: begin
          checks++;
          if ({prog_clk_en, load_busy, load_done, cfg.cfg_ready} !== 4'b1100 || state !== VERIFY) begin
            errors++; $display("FAIL verify_flags: got en/busy/done/ready %b%b%b%b expected 1100",
                               prog_clk_en, load_busy, load_done, cfg.cfg_ready);
          end
          checks++;
          if (ccff_head !== ccff_tail) begin
            errors++; $display("FAIL verify_recirc: got head %b expected tail %b", ccff_head, ccff_tail);
          end
          if (flip && vleft == L) flip_req = 1'b1;
          vleft--;
          if (vleft == 0) phase = 3;
        end
`endif
        default: begin
          done_cyc = cyc;
          finished = 1;
          checks++;
          if ({load_done, load_busy, prog_clk_en, cfg.cfg_ready} !== 4'b1001 || state !== DONE) begin
            errors++; $display("FAIL done_flags: got done/busy/en/ready %b%b%b%b expected 1001",
                               load_done, load_busy, prog_clk_en, cfg.cfg_ready);
          end
          checks++;
          if (load_err !== flip) begin
            errors++; $display("FAIL load_err: got %b expected %b", load_err, flip);
          end
        end
      endcase
      if (acc) begin
        j++;
        a_prev = cyc;
      end
      if (!finished) begin
        @(posedge prog_clk); #1;
        flip_req = 1'b0;
        if (j < NW) begin
          cfg.cfg_data  = words[j];
          cfg.cfg_valid = (cyc + 1 >= a_prev + 1 + gaps[j]);
        end else begin
          cfg.cfg_data  = JUNK;
          cfg.cfg_valid = 1'b1;
        end
      end
    end
    cfg.cfg_valid = 1'b0;
    if (!finished) begin
      errors++; $display("FAIL timeout: got no completion expected done within 400 cycles");
    end
  endtask

  task automatic set_fixed_words();
    words = '{8'hA5, 8'h3C, 8'hC0};
    foreach (gaps[i]) gaps[i] = 0;
  endtask

  task automatic set_random_words(input int max_gap);
    words.delete();
    for (int i = 0; i < NW; i++) begin
      words.push_back(W'($urandom));
      gaps[i] = $urandom_range(max_gap, 0);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cfg.cfg_valid = 1'b0;
    cfg.cfg_data  = '0;
    repeat (3) @(posedge prog_clk);
    @(negedge prog_clk);
    checks++;
    if (cfg.cfg_ready !== 1'b0) begin
      errors++; $display("FAIL ready_in_reset: got %b expected 0", cfg.cfg_ready);
    end
    @(posedge prog_clk); #1;
    reset = 1'b0;
    @(negedge prog_clk);
    checks++;
    if ({ccff_head, prog_clk_en, load_busy, load_done, load_err, cfg.cfg_ready} !== 6'b000001 || state !== IDLE) begin
      errors++; $display("FAIL reset_state: got head/en/busy/done/err/ready %b%b%b%b%b%b state %0d expected 000001 state 0",
                         ccff_head, prog_clk_en, load_busy, load_done, load_err, cfg.cfg_ready, state);
    end
  endtask

  task automatic test_back_to_back();
    set_fixed_words();
    run_load(0, 1'b0);
    checks++;
    if (done_cyc - t0_cyc !== LOAD_CYC) begin
      errors++; $display("FAIL b2b_latency: got %0d expected %0d", done_cyc - t0_cyc, LOAD_CYC);
    end
    checks++;
    if (en_seen !== L) begin
      errors++; $display("FAIL b2b_en_count: got %0d expected %0d", en_seen, L);
    end
    checks++;
    if (chain !== 18'b10_1001_0100_1111_0011) begin
      errors++; $display("FAIL b2b_image: got %h expected %h", chain, 18'b10_1001_0100_1111_0011);
    end
  endtask

  task automatic test_stall();
    set_fixed_words();
    gaps[1] = 10;
    run_load(0, 1'b0);
    checks++;
    if (done_cyc - t0_cyc !== LOAD_CYC + 3) begin
      errors++; $display("FAIL stall_latency: got %0d expected %0d", done_cyc - t0_cyc, LOAD_CYC + 3);
    end
    checks++;
    if (en_seen !== L) begin
      errors++; $display("FAIL stall_en_count: got %0d expected %0d", en_seen, L);
    end
    checks++;
    if (chain !== 18'b10_1001_0100_1111_0011) begin
      errors++; $display("FAIL stall_image: got %h expected %h", chain, 18'b10_1001_0100_1111_0011);
    end
  endtask

  task automatic test_reset_mid();
    set_random_words(0);
    run_load(7, 1'b0);
    @(posedge prog_clk); #1;
    reset = 1'b1;
    @(negedge prog_clk);
    checks++;
    if (cfg.cfg_ready !== 1'b0) begin
      errors++; $display("FAIL midreset_ready: got %b expected 0", cfg.cfg_ready);
    end
    @(posedge prog_clk); #1;
    reset = 1'b0;
    @(negedge prog_clk);
    checks++;
    if ({prog_clk_en, load_busy, load_done, load_err, cfg.cfg_ready} !== 5'b00001 || state !== IDLE) begin
      errors++; $display("FAIL midreset_state: got en/busy/done/err/ready %b%b%b%b%b state %0d expected 00001 state 0",
                         prog_clk_en, load_busy, load_done, load_err, cfg.cfg_ready, state);
    end
    set_random_words(4);
    run_load(0, 1'b0);
    checks++;
    if (chain !== img) begin
      errors++; $display("FAIL midreset_reload_image: got %h expected %h", chain, img);
    end
  endtask

`ifdef CCFF_LOADER_VERIFY_EN
  task automatic test_verify_clean();
    set_random_words(0);
    run_load(0, 1'b0);
    checks++;
    if (done_cyc - t0_cyc !== 2 * L + 1) begin
      errors++; $display("FAIL verify_latency: got %0d expected %0d", done_cyc - t0_cyc, 2 * L + 1);
    end
    checks++;
    if (chain !== img) begin
      errors++; $display("FAIL verify_image_kept: got %h expected %h", chain, img);
    end
  endtask

  task automatic test_verify_flip();
    set_random_words(0);
    run_load(0, 1'b1);
    checks++;
    if (chain !== (img ^ FLIP_MASK)) begin
      errors++; $display("FAIL flip_image: got %h expected %h", chain, img ^ FLIP_MASK);
    end
  endtask
`endif

  task automatic test_restart_from_done();
    checks++;
    if (load_done !== 1'b1) begin
      errors++; $display("FAIL restart_precondition: got done %b expected 1", load_done);
    end
    words.delete();
    words.push_back(8'hFF);
    for (int i = 1; i < NW; i++) words.push_back(W'($urandom));
    foreach (gaps[i]) gaps[i] = 0;
    run_load(0, 1'b0);
    checks++;
    if (chain !== img) begin
      errors++; $display("FAIL restart_image: got %h expected %h", chain, img);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      set_random_words(12);
      run_load(0, 1'b0);
      checks++;
      if (en_seen !== L || chain !== img) begin
        errors++; $display("FAIL random_%0d: got en %0d image %h expected en %0d image %h",
                           it, en_seen, chain, L, img);
      end
    end
  endtask

  initial begin
    cfg.cfg_valid = 1'b0;
    cfg.cfg_data  = '0;
    test_reset();
    test_back_to_back();
    test_stall();
    test_reset_mid();
`ifdef CCFF_LOADER_VERIFY_EN
    test_verify_clean();
    test_verify_flip();
`endif
    test_restart_from_done();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
